// File: rtl/cpstr_pkg.sv
// Shared SLIP symbol defaults and demux state encoding, common to the
// receive and transmit sides of the control-plane stream manager.
package cpstr_pkg;

  localparam logic [7:0] SLIP_MARK     = 8'hC0;
  localparam logic [7:0] SLIP_ESC      = 8'hDB;
  localparam logic [7:0] SLIP_ESC_MARK = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC  = 8'hDD;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_HDR   = 2'd1,
    ST_ROUTE = 2'd2
  } state_t;

endpackage

// File: rtl/slip_unframer.sv
// SLIP byte decoder: flags raw MARKs, resolves escape pairs and reports
// invalid escape sequences. Only esc_pend is stored here.
module slip_unframer
  import cpstr_pkg::*;
#(
  parameter logic [7:0] MARK     = SLIP_MARK,
  parameter logic [7:0] ESC      = SLIP_ESC,
  parameter logic [7:0] ESC_MARK = SLIP_ESC_MARK,
  parameter logic [7:0] ESC_ESC  = SLIP_ESC_ESC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       accept,
  input  logic       in_hunt,
  output logic       mark,
  output logic       dec_valid,
  output logic [7:0] dec_data,
  output logic       esc_err
);

  logic esc_pend;
  logic esc_set;

  // Classify the accepted byte; an ESC seen while hunting is just noise.
  always_comb begin
    mark      = 1'b0;
    dec_valid = 1'b0;
    dec_data  = data;
    esc_err   = 1'b0;
    esc_set   = 1'b0;
    if (accept) begin
      if (data == MARK) begin
        mark = 1'b1;
      end else if (esc_pend) begin
        if (data == ESC_MARK) begin
          dec_valid = 1'b1;
          dec_data  = MARK;
        end else if (data == ESC_ESC) begin
          dec_valid = 1'b1;
          dec_data  = ESC;
        end else begin
          esc_err = 1'b1;
        end
      end else if ((data == ESC) && !in_hunt) begin
        esc_set = 1'b1;
      end else begin
        dec_valid = 1'b1;
      end
    end else begin
      dec_valid = 1'b0;
    end
  end

  // Any accepted byte other than a fresh ESC resolves the pending escape.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_pend <= 1'b0;
    end else if (accept) begin
      esc_pend <= esc_set;
    end else begin
      esc_pend <= esc_pend;
    end
  end

endmodule

// File: rtl/cpstr_mgr_rx.sv
// SLIP-framed stream demultiplexer: header byte selects the stream, data is
// delivered through a one-entry tagged buffer. Optional error counter under
// macro CPSTR_MGR_RX_ERRCNT_EN.
module cpstr_mgr_rx
  import cpstr_pkg::*;
#(
  parameter int         NUM_STREAMS          = 2,
  parameter logic [7:0] SLIP_SYMBOL_MARK     = SLIP_MARK,
  parameter logic [7:0] SLIP_SYMBOL_ESC      = SLIP_ESC,
  parameter logic [7:0] SLIP_SYMBOL_ESC_MARK = SLIP_ESC_MARK,
  parameter logic [7:0] SLIP_SYMBOL_ESC_ESC  = SLIP_ESC_ESC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [8*NUM_STREAMS-1:0] o_data,
  output logic [NUM_STREAMS-1:0]   o_valid,
  input  logic [NUM_STREAMS-1:0]   i_ready,
  output logic                     o_err,
  output logic [15:0]              o_err_cnt
);

  localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  state_t           state;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] buf_idx;
  logic [7:0]       buf_data;
  logic             buf_full;
  logic             accept;
  logic             pop;
  logic             mark;
  logic             dec_valid;
  logic [7:0]       dec_data;
  logic             esc_err;

  // Ready comes only from buffer registers and downstream ready, never i_data.
  assign o_ready = !rst && (!buf_full || i_ready[buf_idx]);
  assign accept  = i_valid && o_ready;
  assign pop     = buf_full && i_ready[buf_idx];

  slip_unframer #(
    .MARK     (SLIP_SYMBOL_MARK),
    .ESC      (SLIP_SYMBOL_ESC),
    .ESC_MARK (SLIP_SYMBOL_ESC_MARK),
    .ESC_ESC  (SLIP_SYMBOL_ESC_ESC)
  ) u_unframer (
    .clk       (clk),
    .rst       (rst),
    .data      (i_data),
    .accept    (accept),
    .in_hunt   (state == ST_HUNT),
    .mark      (mark),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .esc_err   (esc_err)
  );

  // Demux FSM and output buffer; a write always coincides with a free or popping slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HUNT;
      cur_idx  <= '0;
      buf_idx  <= '0;
      buf_data <= 8'h00;
      buf_full <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (pop) begin
        buf_full <= 1'b0;
      end
      if (mark) begin
        state <= ST_HDR;
      end else if (esc_err) begin
        o_err <= 1'b1;
        state <= ST_HUNT;
      end else if (dec_valid) begin
        case (state)
          ST_HDR: begin
            if (int'(dec_data) < NUM_STREAMS) begin
              cur_idx <= dec_data[IDX_W-1:0];
              state   <= ST_ROUTE;
            end else begin
              o_err <= 1'b1;
              state <= ST_HUNT;
            end
          end
          ST_ROUTE: begin
            buf_full <= 1'b1;
            buf_idx  <= cur_idx;
            buf_data <= dec_data;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  // Only the lane matching the buffered tag is valid; data is broadcast.
  always_comb begin
    o_valid = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      o_valid[k] = buf_full && (buf_idx == IDX_W'(k));
    end
  end

  assign o_data = {NUM_STREAMS{buf_data}};

`ifdef CPSTR_MGR_RX_ERRCNT_EN
  logic [15:0] err_cnt;

  // Saturating count of error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 16'h0000;
    end else if (o_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpstr_mgr_rx.sv
// Scoreboard bench for cpstr_mgr_rx (NUM_STREAMS=2): stimulus pushes expected
// bytes per stream, a negedge monitor pops and compares on each transfer.
module tb_cpstr_mgr_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_valid;
  logic [1:0]  i_ready;
  logic        o_err;
  logic [15:0] o_err_cnt;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int exp_err_pulses = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  cpstr_mgr_rx #(.NUM_STREAMS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: transfers happen at the next posedge when valid && ready here.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_err) err_pulses++;
      if (o_valid[0] && q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_s0: got %h expected none", o_data[7:0]);
      end else if (o_valid[0] && i_ready[0]) begin
        logic [7:0] e;
        e = q0.pop_front();
        checks++;
        if (o_data[7:0] !== e) begin
          errors++;
          $display("FAIL s0_data: got %h expected %h", o_data[7:0], e);
        end
      end
      if (o_valid[1] && q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_s1: got %h expected none", o_data[15:8]);
      end else if (o_valid[1] && i_ready[1]) begin
        logic [7:0] e;
        e = q1.pop_front();
        checks++;
        if (o_data[15:8] !== e) begin
          errors++;
          $display("FAIL s1_data: got %h expected %h", o_data[15:8], e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    i_data  = b;
    i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: got o_ready=0 expected 1 for byte %h", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_drain"}, q0.size() + q1.size(), 32'd0);
    chk({name, "_errs"}, err_pulses, exp_err_pulses);
  endtask

  initial begin
    rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_ready = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 32'd0);
    chk("rst_ready", o_ready, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_err", o_err, 32'd0);
    chk("rst_cnt", o_err_cnt, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_ready, 32'd1);

    // Stream 1 only
    q1.push_back(8'h41); q1.push_back(8'h42);
    send(8'hC0); send(8'h01); send(8'h41); send(8'h42);
    drain("t034");

    // Escape decoding
    q0.push_back(8'hC0); q0.push_back(8'hDB); q0.push_back(8'h7E);
    send(8'hC0); send(8'h00); send(8'hDB); send(8'hDC);
    send(8'hDB); send(8'hDD); send(8'h7E);
    drain("t035");

    // Bad header then bad escape
    send(8'hC0); send(8'h05); send(8'h33);
    exp_err_pulses++;
    send(8'hC0); send(8'h00); send(8'hDB); send(8'h41);
    exp_err_pulses++;
    drain("t036");
`ifdef CPSTR_MGR_RX_ERRCNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    chk("t036_cnt", o_err_cnt, exp_cnt);

    // Back-pressure on stream 1
    i_ready = 2'b01;
    q1.push_back(8'hAA); q1.push_back(8'hBB);
    send(8'hC0); send(8'h01); send(8'hAA);
    i_data = 8'hBB; i_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t037_ready_low", o_ready, 32'd0);
      chk("t037_hold", {o_valid[1], o_data[15:8]}, {23'd0, 1'b1, 8'hAA});
    end
    @(posedge clk); #1;
    i_ready = 2'b11;
    send(8'hBB);
    drain("t037");

    // Header switch, streaming and with stall on stream 0
    q0.push_back(8'h11); q1.push_back(8'h22);
    send(8'hC0); send(8'h00); send(8'h11); send(8'hC0); send(8'h01); send(8'h22);
    drain("t038a");
    q0.push_back(8'h11); q1.push_back(8'h22);
    i_ready = 2'b10;
    send(8'hC0); send(8'h00); send(8'h11);
    i_data = 8'hC0; i_valid = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    i_ready = 2'b11;
    send(8'hC0); send(8'h01); send(8'h22);
    drain("t038b");

    // Reset mid-frame with AA still buffered
    i_ready = 2'b00;
    q1.push_back(8'hAA);
    send(8'hC0); send(8'h01); send(8'hAA);
    @(negedge clk);
    chk("t039_buffered", o_valid, 32'd2);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("t039_rst_valid", o_valid, 32'd0);
    chk("t039_rst_ready", o_ready, 32'd0);
    q1.delete();
    @(posedge clk); #1; rst = 1'b0; i_ready = 2'b11;
    q0.push_back(8'h55);
    send(8'h55); send(8'hC0); send(8'h00); send(8'h55);
    drain("t039");
    chk("t039_cnt", o_err_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpstr_mgr_rx.md
CPSTR_MGR_RX -- requirements
Module: cpstr_mgr_rx

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 2, meaning the number of demultiplexed output streams (2..16).
REQ-002 SHALL have parameter SLIP_SYMBOL_MARK, default 8'hC0, meaning the frame mark byte.
REQ-003 SHALL have parameter SLIP_SYMBOL_ESC, default 8'hDB, meaning the escape byte.
REQ-004 SHALL have parameter SLIP_SYMBOL_ESC_MARK, default 8'hDC, meaning the byte that follows ESC to encode MARK.
REQ-005 SHALL have parameter SLIP_SYMBOL_ESC_ESC, default 8'hDD, meaning the byte that follows ESC to encode ESC.
REQ-006 SHALL have port clk, input, width 1, the clock.
REQ-007 SHALL have port rst, input, width 1, the reset, asynchronous and active-high.
REQ-008 SHALL have ports i_data, input, 8, and i_valid, input, 1, carrying the framed byte stream.
REQ-009 SHALL have port o_ready, output, 1, the input-side ready.
REQ-010 SHALL have port o_data, output, 8*NUM_STREAMS, with lane k (bits 8k+7:8k) carrying stream k data.
REQ-011 SHALL have ports o_valid, output, NUM_STREAMS, and i_ready, input, NUM_STREAMS, one bit per stream.
REQ-012 SHALL have port o_err, output, 1, a one-cycle pulse flagging a protocol error.
REQ-013 SHALL have port o_err_cnt, output, 16, the error count (see Configuration).

Function
REQ-014 SHALL accept an input byte when i_valid && o_ready, and SHALL define o_ready = !buf_full || i_ready[buf_idx].
REQ-015 SHALL use states ST_HUNT, ST_HDR and ST_ROUTE, plus an esc_pend flag.
REQ-016 SHALL, on an accepted raw MARK in any state, clear esc_pend and enter ST_HDR; MARK MARK SHALL remain in ST_HDR (empty frame, no error).
REQ-017 SHALL, on an accepted raw ESC outside ST_HUNT, set esc_pend and consume the byte with no output.
REQ-018 SHALL, with esc_pend set, decode ESC_MARK as MARK and ESC_ESC as ESC; any other byte SHALL pulse o_err, be dropped, clear esc_pend and enter ST_HUNT.
REQ-019 SHALL, in ST_HDR, latch a decoded byte below NUM_STREAMS as cur_idx and enter ST_ROUTE; otherwise it SHALL pulse o_err, drop the byte and enter ST_HUNT.
REQ-020 SHALL, in ST_ROUTE, write each decoded data byte into the one-entry output buffer tagged with cur_idx.
REQ-021 SHALL, in ST_HUNT, discard all non-MARK bytes silently without asserting o_err.
REQ-022 SHALL drive o_valid[k] = buf_full && (buf_idx == k), and SHALL present buf_data on every o_data lane.
REQ-023 SHALL have a latency of one cycle, with o_valid asserted the cycle after the data byte is accepted.
REQ-024 SHALL achieve full throughput: simultaneous downstream pop and upstream write in the same cycle SHALL be allowed.
REQ-025 SHALL keep buf_data and buf_idx stable while o_valid is high and i_ready is low.
REQ-026 SHALL let a pending buffered byte keep its own buf_idx when a new header changes cur_idx.
REQ-027 SHALL make the o_ready cone depend only on the registered buffer state and i_ready, never on i_data.

Reset
REQ-028 SHALL, on rst, set state to ST_HUNT, esc_pend=0, buf_full=0, cur_idx=0, buf_idx=0, buf_data=0, o_err=0 and o_err_cnt=0.
REQ-029 SHALL make all outputs low/zero during reset, with o_ready=1 following reset deassertion.

Configuration
REQ-030 SHALL, when macro CPSTR_MGR_RX_ERRCNT_EN is defined, drive o_err_cnt from a 16-bit counter that increments on each o_err pulse and saturates at 16'hFFFF.
REQ-031 SHALL, when CPSTR_MGR_RX_ERRCNT_EN is undefined, tie o_err_cnt to 16'h0000 and leave o_err behaviour unchanged.

Structure
REQ-032 SHALL obtain the default SLIP symbol constants and the state encoding from the shared package cpstr_pkg, which is common with the transmit side.
REQ-033 SHALL place SLIP decoding (MARK detection, escape handling, error flagging) in the sub-module slip_unframer, with the demultiplexer FSM and output buffer kept in cpstr_mgr_rx.

Verification (NUM_STREAMS=2)
REQ-034 SHALL test input C0 01 41 42 -> stream 1 receives 41 then 42, and o_valid[0] is never asserted.
REQ-035 SHALL test input C0 00 DB DC DB DD 7E -> stream 0 receives C0, DB, 7E.
REQ-036 SHALL test input C0 05 33, then DB 41 inside a frame -> o_err pulses once for each, 33 and 41 are dropped, and o_err_cnt=2 (macro defined) or 0 (macro undefined).
REQ-037 SHALL test input C0 01 AA BB with i_ready[1]=0 for 10 cycles -> o_ready is held low, AA is stable, then AA and BB are delivered in order with no loss.
REQ-038 SHALL test input C0 00 11 C0 01 22 -> stream 0 receives 11 and stream 1 receives 22, including the case where 11 is still buffered when header 01 arrives.
REQ-039 SHALL test rst asserted after C0 01 AA, followed by input 55 C0 00 55 -> the first 55 is dropped without o_err, and stream 0 receives 55.
